// File: rtl/reset_sequencer_pf_if.sv
// Bundles the sequencer's subsystem-facing signals: the staged resets and
// status flowing out, and ready acknowledges plus soft-reset request flowing in.
interface reset_sequencer_pf_if #(
  parameter int NUM_STAGES = 4
);
  logic                  SOFT_RST_REQ;
  logic [NUM_STAGES-1:0] STAGE_READY;
  logic [NUM_STAGES-1:0] STAGE_RESET_N;
  logic                  ALL_RELEASED;
  logic                  SOFT_RST_ACK;
  logic                  TIMEOUT_ERR;
  logic [2:0]            ERR_STAGE;

  // Sequencer side.
  modport master (
    input  SOFT_RST_REQ,
    input  STAGE_READY,
    output STAGE_RESET_N,
    output ALL_RELEASED,
    output SOFT_RST_ACK,
    output TIMEOUT_ERR,
    output ERR_STAGE
  );

  // Subsystem / supervisor side.
  modport slave (
    output SOFT_RST_REQ,
    output STAGE_READY,
    input  STAGE_RESET_N,
    input  ALL_RELEASED,
    input  SOFT_RST_ACK,
    input  TIMEOUT_ERR,
    input  ERR_STAGE
  );
endinterface

// File: rtl/reset_sequencer_pf.sv
// Staged reset release controller. Releases up to eight subsystem resets in
// order, each after a programmable delay and an optional ready acknowledge
// from the stage just released. A soft-reset request re-asserts the stages
// in reverse order, holds, and then repeats the release sequence.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   WAIT_DLY | counting STAGE_DELAY before releasing stage idx
//   WAIT_ACK | stage idx released, waiting for its ready or the timeout
//   DONE     | all stages released, soft-reset request may be accepted
//   SHUTDOWN | re-asserting stages top-down, one every STAGE_DELAY cycles
//   HOLD     | all stages in reset until the soft-reset request drops
module reset_sequencer_pf #(
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_DELAY = 16,
  parameter int ACK_TIMEOUT = 1024,
  parameter int CNT_W       = 16
) (
  input  logic                 CLK,
  input  logic                 FABRIC_RESET_N,
  reset_sequencer_pf_if.master seq
);

  localparam logic [2:0] WAIT_DLY = 3'd0;
  localparam logic [2:0] WAIT_ACK = 3'd1;
  localparam logic [2:0] DONE     = 3'd2;
  localparam logic [2:0] SHUTDOWN = 3'd3;
  localparam logic [2:0] HOLD     = 3'd4;

  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [2:0]       LAST_IDX = 3'(NUM_STAGES - 1);
  localparam bit               ACK_EN   = (ACK_TIMEOUT != 0);
  // The cycle that accepts a ready also counts as the first delay cycle of
  // the next stage, so release lands STAGE_DELAY edges after the
  // synchroniser captures the ready. A one-cycle delay cannot overlap.
  localparam logic [CNT_W-1:0] ACK_SKIP = (STAGE_DELAY > 1) ? CNT_W'(1) : '0;

  logic [NUM_STAGES-1:0] ready_meta;
  logic [NUM_STAGES-1:0] ready_sync;
  logic                  ready_cur;
  logic [NUM_STAGES-1:0] idx_oh;
  logic [NUM_STAGES-1:0] idx_m1_oh;

  logic [2:0]            state;
  logic [2:0]            idx;
  logic [CNT_W-1:0]      cnt;
  logic [NUM_STAGES-1:0] stage_rst_n_q;
  logic                  all_rel_q;
  logic                  soft_ack_q;
  logic                  terr_q;
  logic [2:0]            err_stage_q;

  // Two-flop synchroniser on every ready bit; the subsystems run on their own clocks.
  always_ff @(posedge CLK or negedge FABRIC_RESET_N) begin
    if (!FABRIC_RESET_N) begin
      ready_meta <= '0;
      ready_sync <= '0;
    end else begin
      ready_meta <= seq.STAGE_READY;
      ready_sync <= ready_meta;
    end
  end

  // Decode the stage index into the stage being released and the one below it.
  always_comb begin
    ready_cur = 1'b0;
    idx_oh    = '0;
    idx_m1_oh = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (int'(idx) == i) begin
        idx_oh[i] = 1'b1;
        ready_cur = ready_sync[i];
      end
      if (int'(idx) == i + 1) begin
        idx_m1_oh[i] = 1'b1;
      end
    end
  end

  // Sequencer FSM: release, acknowledge, shutdown and hold, sharing one counter.
  always_ff @(posedge CLK or negedge FABRIC_RESET_N) begin
    if (!FABRIC_RESET_N) begin
      state         <= WAIT_DLY;
      idx           <= 3'd0;
      cnt           <= '0;
      stage_rst_n_q <= '0;
      all_rel_q     <= 1'b0;
      soft_ack_q    <= 1'b0;
      terr_q        <= 1'b0;
      err_stage_q   <= 3'd0;
    end else begin
      soft_ack_q <= 1'b0;
      case (state)
        WAIT_DLY: begin
          if (cnt == DLY_LAST) begin
            stage_rst_n_q <= stage_rst_n_q | idx_oh;
            cnt           <= '0;
            if (ACK_EN) begin
              state <= WAIT_ACK;
            end else if (idx == LAST_IDX) begin
              state     <= DONE;
              all_rel_q <= 1'b1;
            end else begin
              idx   <= idx + 3'd1;
              state <= WAIT_DLY;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        WAIT_ACK: begin
          if (ready_cur || (cnt == ACK_LAST)) begin
            cnt <= ready_cur ? ACK_SKIP : '0;
            // Only the first stage to time out is recorded.
            if (!ready_cur && !terr_q) begin
              terr_q      <= 1'b1;
              err_stage_q <= idx;
            end
            if (idx == LAST_IDX) begin
              state     <= DONE;
              all_rel_q <= 1'b1;
            end else begin
              idx   <= idx + 3'd1;
              state <= WAIT_DLY;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DONE: begin
          if (seq.SOFT_RST_REQ) begin
            all_rel_q     <= 1'b0;
            stage_rst_n_q <= stage_rst_n_q & ~idx_oh;
            idx           <= LAST_IDX;
            cnt           <= '0;
            // A single-stage build has nothing left to shut down.
            if (LAST_IDX == 3'd0) begin
              soft_ack_q <= 1'b1;
              state      <= HOLD;
            end else begin
              state <= SHUTDOWN;
            end
          end
        end

        SHUTDOWN: begin
          if (cnt == DLY_LAST) begin
            cnt           <= '0;
            idx           <= idx - 3'd1;
            stage_rst_n_q <= stage_rst_n_q & ~idx_m1_oh;
            if (idx == 3'd1) begin
              soft_ack_q <= 1'b1;
              state      <= HOLD;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        HOLD: begin
          if (!seq.SOFT_RST_REQ) begin
            idx   <= 3'd0;
            cnt   <= '0;
            state <= WAIT_DLY;
          end
        end

        default: begin
          state <= WAIT_DLY;
          idx   <= 3'd0;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign seq.STAGE_RESET_N = stage_rst_n_q;
  assign seq.ALL_RELEASED  = all_rel_q;
  assign seq.SOFT_RST_ACK  = soft_ack_q;
  assign seq.TIMEOUT_ERR   = terr_q;
  assign seq.ERR_STAGE     = err_stage_q;

endmodule

// File: tb/tb_reset_sequencer_pf.sv
// Directed bench: four sequencer instances sharing clock and fabric reset.
//   a: no acknowledge, soft-reset pulse in DONE
//   b: acknowledge with long timeout, ready driven late
//   c: acknowledge timeout of 100, stage 1 never ready
//   d: no acknowledge, soft-reset request held from the start
module tb_reset_sequencer_pf;

  logic CLK = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cur      = 0;

  always #5 CLK = ~CLK;

  reset_sequencer_pf_if #(.NUM_STAGES(4)) if_a ();
  reset_sequencer_pf_if #(.NUM_STAGES(4)) if_b ();
  reset_sequencer_pf_if #(.NUM_STAGES(4)) if_c ();
  reset_sequencer_pf_if #(.NUM_STAGES(4)) if_d ();

  reset_sequencer_pf #(.NUM_STAGES(4), .STAGE_DELAY(16), .ACK_TIMEOUT(0), .CNT_W(16))
    dut_a (.CLK(CLK), .FABRIC_RESET_N(rst_n), .seq(if_a));
  reset_sequencer_pf #(.NUM_STAGES(4), .STAGE_DELAY(16), .ACK_TIMEOUT(1024), .CNT_W(16))
    dut_b (.CLK(CLK), .FABRIC_RESET_N(rst_n), .seq(if_b));
  reset_sequencer_pf #(.NUM_STAGES(4), .STAGE_DELAY(16), .ACK_TIMEOUT(100), .CNT_W(16))
    dut_c (.CLK(CLK), .FABRIC_RESET_N(rst_n), .seq(if_c));
  reset_sequencer_pf #(.NUM_STAGES(4), .STAGE_DELAY(16), .ACK_TIMEOUT(0), .CNT_W(16))
    dut_d (.CLK(CLK), .FABRIC_RESET_N(rst_n), .seq(if_d));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the given rising edge (edge 1 = first with reset high).
  task automatic step_to(input int e);
    while (cur < e) begin
      @(posedge CLK);
      cur++;
    end
    #1;
  endtask

  // Pulse fabric reset between clock edges and restart the edge count.
  task automatic fabric_reset_pulse();
    rst_n = 1'b0;
    #1;
    chk("async_rst_a", 8'(if_a.STAGE_RESET_N), 8'h0);
    chk("async_rst_b", 8'(if_b.STAGE_RESET_N), 8'h0);
    chk("async_rst_c", 8'(if_c.STAGE_RESET_N), 8'h0);
    chk("async_rst_d", 8'(if_d.STAGE_RESET_N), 8'h0);
    chk("async_allrel_a", 8'(if_a.ALL_RELEASED), 8'h0);
    chk("async_terr_c", 8'(if_c.TIMEOUT_ERR), 8'h0);
    chk("async_errstg_c", 8'(if_c.ERR_STAGE), 8'h0);
    chk("async_ack_d", 8'(if_d.SOFT_RST_ACK), 8'h0);
    rst_n = 1'b1;
    cur   = 0;
  endtask

  initial begin
    rst_n              = 1'b1;
    if_a.SOFT_RST_REQ  = 1'b0;
    if_a.STAGE_READY   = 4'b0000;
    if_b.SOFT_RST_REQ  = 1'b0;
    if_b.STAGE_READY   = 4'b0000;
    if_c.SOFT_RST_REQ  = 1'b0;
    if_c.STAGE_READY   = 4'b1101;
    if_d.SOFT_RST_REQ  = 1'b1;
    if_d.STAGE_READY   = 4'b0000;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_stage_a", 8'(if_a.STAGE_RESET_N), 8'h0);
    chk("rst_stage_c", 8'(if_c.STAGE_RESET_N), 8'h0);
    chk("rst_allrel_a", 8'(if_a.ALL_RELEASED), 8'h0);
    chk("rst_ack_d", 8'(if_d.SOFT_RST_ACK), 8'h0);
    chk("rst_terr_c", 8'(if_c.TIMEOUT_ERR), 8'h0);
    chk("rst_errstg_c", 8'(if_c.ERR_STAGE), 8'h0);
    rst_n = 1'b1;
    cur   = 0;

    // ---- first run ----
    step_to(15);  chk("a_e15", 8'(if_a.STAGE_RESET_N), 8'h0);
                  chk("c_e15", 8'(if_c.STAGE_RESET_N), 8'h0);
    step_to(16);  chk("a_e16", 8'(if_a.STAGE_RESET_N), 8'h1);
                  chk("b_e16", 8'(if_b.STAGE_RESET_N), 8'h1);
                  chk("c_e16", 8'(if_c.STAGE_RESET_N), 8'h1);
                  chk("d_e16_req_ignored", 8'(if_d.STAGE_RESET_N), 8'h1);
    step_to(31);  chk("a_e31", 8'(if_a.STAGE_RESET_N), 8'h1);
                  chk("c_e31", 8'(if_c.STAGE_RESET_N), 8'h1);
    step_to(32);  chk("a_e32", 8'(if_a.STAGE_RESET_N), 8'h3);
                  chk("c_e32", 8'(if_c.STAGE_RESET_N), 8'h3);
    step_to(40);  if_b.STAGE_READY = 4'b0001;
    step_to(47);  chk("a_e47", 8'(if_a.STAGE_RESET_N), 8'h3);
    step_to(48);  chk("a_e48", 8'(if_a.STAGE_RESET_N), 8'h7);
    step_to(57);  chk("b_e57", 8'(if_b.STAGE_RESET_N), 8'h1);
    step_to(58);  chk("b_e58", 8'(if_b.STAGE_RESET_N), 8'h3);
                  chk("b_terr_e58", 8'(if_b.TIMEOUT_ERR), 8'h0);
    step_to(60);  if_b.STAGE_READY = 4'b0011;
    step_to(63);  chk("a_e63", 8'(if_a.STAGE_RESET_N), 8'h7);
                  chk("a_allrel_e63", 8'(if_a.ALL_RELEASED), 8'h0);
    step_to(64);  chk("a_e64", 8'(if_a.STAGE_RESET_N), 8'hF);
                  chk("a_allrel_e64", 8'(if_a.ALL_RELEASED), 8'h1);
                  chk("d_e64", 8'(if_d.STAGE_RESET_N), 8'hF);
                  chk("d_allrel_e64", 8'(if_d.ALL_RELEASED), 8'h1);
    step_to(65);  chk("d_accept_e65", 8'(if_d.STAGE_RESET_N), 8'h7);
                  chk("d_allrel_e65", 8'(if_d.ALL_RELEASED), 8'h0);
    step_to(70);  if_a.SOFT_RST_REQ = 1'b1;
    step_to(71);  chk("a_accept_e71", 8'(if_a.STAGE_RESET_N), 8'h7);
                  chk("a_allrel_e71", 8'(if_a.ALL_RELEASED), 8'h0);
    step_to(78);  chk("b_e78", 8'(if_b.STAGE_RESET_N), 8'h7);
    step_to(81);  chk("d_e81", 8'(if_d.STAGE_RESET_N), 8'h3);
    step_to(86);  chk("a_e86", 8'(if_a.STAGE_RESET_N), 8'h7);
    step_to(87);  chk("a_e87", 8'(if_a.STAGE_RESET_N), 8'h3);
    step_to(97);  chk("d_e97", 8'(if_d.STAGE_RESET_N), 8'h1);
    step_to(103); chk("a_e103", 8'(if_a.STAGE_RESET_N), 8'h1);
    step_to(112); chk("d_e112", 8'(if_d.STAGE_RESET_N), 8'h1);
                  chk("d_ack_e112", 8'(if_d.SOFT_RST_ACK), 8'h0);
    step_to(113); chk("d_e113", 8'(if_d.STAGE_RESET_N), 8'h0);
                  chk("d_ack_e113", 8'(if_d.SOFT_RST_ACK), 8'h1);
    step_to(118); chk("a_ack_e118", 8'(if_a.SOFT_RST_ACK), 8'h0);
    step_to(119); chk("a_e119", 8'(if_a.STAGE_RESET_N), 8'h0);
                  chk("a_ack_e119", 8'(if_a.SOFT_RST_ACK), 8'h1);
    step_to(120); chk("a_ack_e120", 8'(if_a.SOFT_RST_ACK), 8'h0);
    step_to(131); chk("c_terr_e131", 8'(if_c.TIMEOUT_ERR), 8'h0);
    step_to(132); chk("c_terr_e132", 8'(if_c.TIMEOUT_ERR), 8'h1);
                  chk("c_errstg_e132", 8'(if_c.ERR_STAGE), 8'h1);
    step_to(147); chk("c_e147", 8'(if_c.STAGE_RESET_N), 8'h3);
    step_to(148); chk("c_e148", 8'(if_c.STAGE_RESET_N), 8'h7);
    step_to(170); chk("c_e170", 8'(if_c.STAGE_RESET_N), 8'hF);
                  chk("c_allrel_e170", 8'(if_c.ALL_RELEASED), 8'h1);
                  chk("c_errstg_e170", 8'(if_c.ERR_STAGE), 8'h1);
    step_to(270); if_a.SOFT_RST_REQ = 1'b0;
    step_to(286); chk("a_hold_e286", 8'(if_a.STAGE_RESET_N), 8'h0);
    step_to(287); chk("a_rerel_e287", 8'(if_a.STAGE_RESET_N), 8'h1);
    step_to(300); chk("b_waitack2_e300", 8'(if_b.STAGE_RESET_N), 8'h7);
                  chk("c_terr_e300", 8'(if_c.TIMEOUT_ERR), 8'h1);
    fabric_reset_pulse();

    // ---- second run: restart after reset during b's stage-2 acknowledge wait ----
    step_to(15);  chk("r2_a_e15", 8'(if_a.STAGE_RESET_N), 8'h0);
    step_to(16);  chk("r2_a_e16", 8'(if_a.STAGE_RESET_N), 8'h1);
    step_to(32);  chk("r2_a_e32", 8'(if_a.STAGE_RESET_N), 8'h3);
                  chk("r2_b_e32", 8'(if_b.STAGE_RESET_N), 8'h3);
                  chk("r2_c_e32", 8'(if_c.STAGE_RESET_N), 8'h3);
    step_to(40);  chk("r2_c_terr_e40", 8'(if_c.TIMEOUT_ERR), 8'h0);
    step_to(48);  chk("r2_b_e48", 8'(if_b.STAGE_RESET_N), 8'h7);
    step_to(64);  chk("r2_a_e64", 8'(if_a.STAGE_RESET_N), 8'hF);
                  chk("r2_d_e64", 8'(if_d.STAGE_RESET_N), 8'hF);
    step_to(65);  chk("r2_d_e65", 8'(if_d.STAGE_RESET_N), 8'h7);
    step_to(90);  chk("r2_d_shutdown_e90", 8'(if_d.STAGE_RESET_N), 8'h3);
    fabric_reset_pulse();

    // ---- third run: restart after reset during d's shutdown ----
    step_to(15);  chk("r3_d_e15", 8'(if_d.STAGE_RESET_N), 8'h0);
    step_to(16);  chk("r3_a_e16", 8'(if_a.STAGE_RESET_N), 8'h1);
                  chk("r3_d_e16", 8'(if_d.STAGE_RESET_N), 8'h1);
    step_to(32);  chk("r3_a_e32", 8'(if_a.STAGE_RESET_N), 8'h3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sequencer_pf.md
# reset_sequencer_pf

Staged reset release controller for the fabric. It consumes the synchronised fabric reset and releases up to eight downstream subsystem resets in a fixed order. Each stage waits a programmable delay and, optionally, a ready acknowledge from the subsystem released before it. A soft-reset request path re-asserts the stages in reverse order and then repeats the release sequence.

## Interface
- NUM_STAGES, 4: number of reset stages (1..8)
- STAGE_DELAY, 16: CLK cycles between the start of a stage's wait and its release (1..2^CNT_W-1)
- ACK_TIMEOUT, 1024: maximum cycles to wait for STAGE_READY[i]; 0 disables the acknowledge wait (0..2^CNT_W-1)
- CNT_W, 16: width of the shared delay/timeout counter

- CLK  in  1  single clock
- FABRIC_RESET_N  in  1  reset, asynchronous and active-low; deassertion is synchronous to CLK
- SOFT_RST_REQ  in  1  level request for an orderly re-reset, CLK domain
- STAGE_READY  in  NUM_STAGES  per-stage ready from subsystems, any domain
- STAGE_RESET_N  out  NUM_STAGES  per-stage active-low reset, registered
- ALL_RELEASED  out  1  high when all stages are released and the sequencer is idle
- SOFT_RST_ACK  out  1  one-cycle pulse when the soft-reset shutdown completes
- TIMEOUT_ERR  out  1  sticky; set on the first acknowledge timeout
- ERR_STAGE  out  3  index of the first stage that timed out

## Operation
- STAGE_READY passes through a per-bit 2-flop synchroniser. Reset value of the synchroniser flops is 0.
- State machine states: WAIT_DLY, WAIT_ACK, DONE, SHUTDOWN, HOLD. There is a stage index `idx` and one counter `cnt`.
- While FABRIC_RESET_N is low:
  - state = WAIT_DLY, idx = 0, cnt = 0
  - STAGE_RESET_N = 0, ALL_RELEASED = 0, SOFT_RST_ACK = 0, TIMEOUT_ERR = 0, ERR_STAGE = 0
- WAIT_DLY:
  - cnt increments each cycle.
  - When cnt == STAGE_DELAY-1: set STAGE_RESET_N[idx] = 1 and clear cnt.
  - Then go to WAIT_ACK, or, if ACK_TIMEOUT == 0, advance directly.
- Advance:
  - If idx == NUM_STAGES-1, go to DONE and set ALL_RELEASED = 1 on the same edge as the last release.
  - Otherwise idx++ and go to WAIT_DLY.
- WAIT_ACK:
  - If synced STAGE_READY[idx] == 1, advance. A ready that was already high before release is accepted on the first WAIT_ACK cycle.
  - Otherwise cnt increments. When cnt == ACK_TIMEOUT-1, advance anyway.
  - If TIMEOUT_ERR == 0 at that point, set TIMEOUT_ERR = 1 and ERR_STAGE = idx. Later timeouts do not overwrite ERR_STAGE.
- STAGE_READY is ignored in every state other than WAIT_ACK. A ready that drops after acknowledge has no effect.
- DONE:
  - SOFT_RST_REQ = 1 is accepted. On that edge: ALL_RELEASED = 0, STAGE_RESET_N[NUM_STAGES-1] = 0, idx = NUM_STAGES-1, cnt = 0, go to SHUTDOWN.
- SOFT_RST_REQ is not accepted in WAIT_DLY or WAIT_ACK. A level still held high is accepted on the first DONE cycle.
- SHUTDOWN:
  - cnt increments. When cnt == STAGE_DELAY-1: idx--, STAGE_RESET_N[idx] = 0, cnt = 0.
  - When stage 0 is asserted, pulse SOFT_RST_ACK on the same edge and go to HOLD.
- HOLD:
  - All stages stay in reset until SOFT_RST_REQ == 0.
  - Then idx = 0, cnt = 0, go to WAIT_DLY, and the full release sequence repeats.
  - TIMEOUT_ERR and ERR_STAGE are kept; only FABRIC_RESET_N clears them.
- Invariant: STAGE_RESET_N is always thermometer-coded. Stage i is never released while any stage j<i is in reset.

## Timing
- Edge 1 is the first CLK rising edge with FABRIC_RESET_N high.
- Release timing:
  - Stage 0 is released at edge STAGE_DELAY.
  - With ACK_TIMEOUT = 0, stage i is released at edge (i+1)*STAGE_DELAY.
  - With acknowledge: stage i+1 is released STAGE_DELAY edges after the edge that samples synced ready[i]. Synced ready[i] lags raw ready by 2 edges.
- Timeout: if no ready arrives, the next stage is released at release_i + ACK_TIMEOUT + STAGE_DELAY, and TIMEOUT_ERR is set at release_i + ACK_TIMEOUT.
- Mid-operation reset: FABRIC_RESET_N low at any time forces all outputs to their reset values asynchronously, with no waiting for CLK.
- Soft-reset latency, from the accept edge to SOFT_RST_ACK: (NUM_STAGES-1)*STAGE_DELAY edges.

## Test plan
- NUM_STAGES=4, STAGE_DELAY=16, ACK_TIMEOUT=0, release reset -> STAGE_RESET_N goes 0001, 0011, 0111, 1111 at edges 16, 32, 48, 64; ALL_RELEASED rises at edge 64.
- ACK_TIMEOUT=1024, raw STAGE_READY[0] rises at edge 40 -> stage 1 released at edge 58 (sampled at 42, +16); no TIMEOUT_ERR.
- ACK_TIMEOUT=100, STAGE_READY[1] held 0, others ready high -> TIMEOUT_ERR = 1 at edge 132 (stage 1 released at 32, +100), ERR_STAGE = 1, stage 2 released at edge 148; later stages still complete.
- In DONE, pulse SOFT_RST_REQ high for 200 cycles -> stage 3 asserted at the accept edge, stage 2 at +16, stage 1 at +32, stage 0 plus SOFT_RST_ACK at +48. Release restarts after REQ falls; stage 0 re-releases 16 edges later.
- SOFT_RST_REQ high from edge 1 -> request ignored until DONE, then shutdown starts at the DONE edge +1.
- FABRIC_RESET_N pulsed low during WAIT_ACK of stage 2, and again during SHUTDOWN -> all STAGE_RESET_N = 0 immediately. TIMEOUT_ERR is cleared, and the sequence restarts from stage 0 with the original edge counts.
